// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC engines: Q3.16 angle constants,
// the micro-rotation arctangent table and the iterative engine state type.
package cordic_pkg;

  localparam int PI   = 205887;
  localparam int PI_2 = 102944;
  localparam int X0   = 39797;   // 1/gain of the 16-step rotation sequence

  localparam int ATAN_TAB [0:15] = '{
    51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
    256,   128,   64,    32,   16,   8,    4,    2
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, atan(2^-i) in Q3.16.
// Sized for any datapath width so the arcsine pipeline can reuse it.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int W = 20
) (
  input  logic [3:0]   i_idx,
  output logic [W-1:0] o_atan
);

  always_comb begin
    o_atan = W'(ATAN_TAB[i_idx]);
  end

endmodule

// File: rtl/cordic_rotate_iter.sv
// Iterative rotation-mode CORDIC: drives the residual angle toward zero and
// returns cos/sin of the accepted angle through a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for an angle, in_ready high
// RUN   | one micro-rotation per cycle, then register the result
// DONE  | result held with out_valid high until out_ready
module cordic_rotate_iter
  import cordic_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] z_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] cos_out,
  output logic [W-1:0] sin_out,
  output logic [W-1:0] z_res,
  output logic         range_err
);

  localparam logic signed [W-1:0] C_PI   = W'(PI);
  localparam logic signed [W-1:0] C_PI_2 = W'(PI_2);
  localparam logic signed [W-1:0] C_X0   = W'(X0);
  localparam logic [4:0]          C_LAST = 5'(N);

  state_t r_state;
  state_t w_next;

  logic                r_in_ready;
  logic                r_out_valid;
  logic [4:0]          r_iter;
  logic signed [W-1:0] r_x;
  logic signed [W-1:0] r_y;
  logic signed [W-1:0] r_z;
  logic                r_neg;
  logic                r_rerr;
  logic [W-1:0]        r_cos;
  logic [W-1:0]        r_sin;
  logic [W-1:0]        r_zres;
  logic                r_range_err;

  logic signed [W-1:0] w_zin;
  logic signed [W-1:0] w_z_fold;
  logic                w_fold_neg;
  logic                w_rerr;
  logic                w_accept;
  logic                w_last;
  logic [W-1:0]        w_atan;
  logic                w_d_pos;
  logic signed [W-1:0] w_x_sh;
  logic signed [W-1:0] w_y_sh;
  logic signed [W-1:0] w_x_nx;
  logic signed [W-1:0] w_y_nx;
  logic signed [W-1:0] w_z_nx;

  assign w_zin    = $signed(z_in);
  assign w_accept = (r_state == IDLE) && in_valid && r_in_ready;
  assign w_last   = (r_iter == C_LAST);

  // Fold outer quadrants by pi; the sign flip is restored at the output.
  always_comb begin
    w_z_fold   = w_zin;
    w_fold_neg = 1'b0;
    if (w_zin > C_PI_2) begin
      w_z_fold   = w_zin - C_PI;
      w_fold_neg = 1'b1;
    end else if (w_zin < -C_PI_2) begin
      w_z_fold   = w_zin + C_PI;
      w_fold_neg = 1'b1;
    end
    w_rerr = (w_zin > C_PI) || (w_zin < -C_PI);
  end

  cordic_atan_rom #(.W(W)) u_atan_rom (
    .i_idx  (r_iter[3:0]),
    .o_atan (w_atan)
  );

  always_comb begin
    w_d_pos = ~r_z[W-1];
    w_x_sh  = r_x >>> r_iter[3:0];
    w_y_sh  = r_y >>> r_iter[3:0];
    if (w_d_pos) begin
      w_x_nx = r_x - w_y_sh;
      w_y_nx = r_y + w_x_sh;
      w_z_nx = r_z - $signed(w_atan);
    end else begin
      w_x_nx = r_x + w_y_sh;
      w_y_nx = r_y - w_x_sh;
      w_z_nx = r_z + $signed(w_atan);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == IDLE);
      r_out_valid <= (w_next == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_iter      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_neg       <= 1'b0;
      r_rerr      <= 1'b0;
      r_cos       <= '0;
      r_sin       <= '0;
      r_zres      <= '0;
      r_range_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_iter <= '0;
            r_x    <= C_X0;
            r_y    <= '0;
            r_z    <= w_z_fold;
            r_neg  <= w_fold_neg;
            r_rerr <= w_rerr;
          end
        end
        RUN: begin
          // Extra cycle after the last rotation registers the unfolded result.
          if (w_last) begin
            r_cos       <= r_neg ? -r_x : r_x;
            r_sin       <= r_neg ? -r_y : r_y;
            r_zres      <= r_z;
            r_range_err <= r_rerr;
            r_iter      <= '0;
          end else begin
            r_x    <= w_x_nx;
            r_y    <= w_y_nx;
            r_z    <= w_z_nx;
            r_iter <= r_iter + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign cos_out   = r_cos;
  assign sin_out   = r_sin;
  assign z_res     = r_zres;
  assign range_err = r_range_err;

endmodule

// File: tb/tb_cordic_rotate_iter.sv
// Self-checking bench for cordic_rotate_iter: directed and random angles
// compared against real-valued cos/sin and an integer residual-angle model.
module tb_cordic_rotate_iter;

  localparam int N  = 16;
  localparam int W  = 20;
  localparam int PI = 205887;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] z_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] cos_out;
  logic [W-1:0] sin_out;
  logic [W-1:0] z_res;
  logic         range_err;

  int n_chk = 0;
  int n_err = 0;

  int atan_ref [16] = '{51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
                        256, 128, 64, 32, 16, 8, 4, 2};

  cordic_rotate_iter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_out   (cos_out),
    .sin_out   (sin_out),
    .z_res     (z_res),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    n_chk++;
    if (obs - exp > tol || exp - obs > tol) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int ref_cos(input int z);
    return $rtoi($floor($cos(real'(z) / 65536.0) * 65536.0 + 0.5));
  endfunction

  function automatic int ref_sin(input int z);
    return $rtoi($floor($sin(real'(z) / 65536.0) * 65536.0 + 0.5));
  endfunction

  // Residual angle: fold into [-pi/2, pi/2], then greedily drive toward zero.
  function automatic int ref_zres(input int z);
    int r;
    r = z;
    if (z > PI / 2 + 1) r = z - PI;
    else if (z < -(PI / 2 + 1)) r = z + PI;
    for (int i = 0; i < N; i++) begin
      if (r >= 0) r = r - atan_ref[i];
      else        r = r + atan_ref[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int z, input int hold, input int tol, input bit chk_cs);
    int cyc;
    bit seen;
    int c0, s0, zr0, re0;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("in_ready_wait", int'(in_ready), 1, 0);
    in_valid = 1'b1;
    z_in     = W'(z);
    tick();
    in_valid = 1'b0;
    z_in     = W'($urandom);
    chk("in_ready_busy", int'(in_ready), 0, 0);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 40 && !seen) begin
      tick();
      cyc++;
      if (out_valid) seen = 1'b1;
    end
    chk("latency", cyc, N + 1, 0);
    if (chk_cs) begin
      chk("cos", sx(cos_out), ref_cos(z), tol);
      chk("sin", sx(sin_out), ref_sin(z), tol);
    end
    chk("z_res", sx(z_res), ref_zres(z), 0);
    chk("range_err", int'(range_err), int'(z > PI || z < -PI), 0);
    c0  = sx(cos_out);
    s0  = sx(sin_out);
    zr0 = sx(z_res);
    re0 = int'(range_err);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      z_in     = W'($urandom);
      tick();
      chk("hold_valid", int'(out_valid), 1, 0);
      chk("hold_in_ready", int'(in_ready), 0, 0);
      chk("hold_cos", sx(cos_out), c0, 0);
      chk("hold_sin", sx(sin_out), s0, 0);
      chk("hold_zres", sx(z_res), zr0, 0);
      chk("hold_rerr", int'(range_err), re0, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", int'(out_valid), 0, 0);
    chk("release_in_ready", int'(in_ready), 1, 0);
  endtask

  initial begin
    int z;
    int seen_cnt;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    z_in      = '0;
    repeat (3) tick();
    chk("rst_in_ready", int'(in_ready), 0, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_cos", sx(cos_out), 0, 0);
    chk("rst_sin", sx(sin_out), 0, 0);
    chk("rst_zres", sx(z_res), 0, 0);
    chk("rst_rerr", int'(range_err), 0, 0);
    reset = 1'b1;
    chk("rel_in_ready_pre", int'(in_ready), 0, 0);
    tick();
    chk("rel_in_ready_post", int'(in_ready), 1, 0);

    run_op(0, 0, 4, 1'b1);
    run_op(51472, 0, 6, 1'b1);
    run_op(205887, 0, 4, 1'b1);
    run_op(-102944, 0, 4, 1'b1);
    run_op(262144, 0, 0, 1'b0);
    run_op(-70000, 0, 6, 1'b1);
    run_op(120000, 5, 6, 1'b1);

    // Abort mid-run at iteration 7.
    in_valid = 1'b1;
    z_in     = W'(40000);
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_out_valid", int'(out_valid), 0, 0);
    chk("abort_in_ready", int'(in_ready), 0, 0);
    chk("abort_cos", sx(cos_out), 0, 0);
    chk("abort_sin", sx(sin_out), 0, 0);
    chk("abort_zres", sx(z_res), 0, 0);
    chk("abort_rerr", int'(range_err), 0, 0);
    seen_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (out_valid) seen_cnt++;
    end
    chk("abort_no_result", seen_cnt, 0, 0);
    run_op(40000, 0, 6, 1'b1);

    for (int r = 0; r < 20; r++) begin
      z = int'($urandom_range(2 * PI, 0)) - PI;
      run_op(z, int'($urandom_range(3, 0)), 24, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
